// File: rtl/dn_bus_arbiter.sv
// dn_bus_arbiter: owns the shared ROM/NVRAM load bus and shares it between
// the HPS ioctl download stream (always wins) and single-byte hiscore
// accesses, which are only performed while the CPU is held paused.
//
// Requester handshake: hs_req is a level held through the hs_ack cycle.
// The arbiter samples hs_req/hs_we/hs_addr/hs_wdata at the end of the ack
// cycle to decide on a burst, so a requester that wants back-to-back
// accesses presents its next request during the ack cycle, and one that is
// finished drops hs_req in that same cycle.
`timescale 1ns/1ps

module dn_bus_arbiter #(
    parameter int AW       = 16,
    parameter int NVAW     = 10,
    parameter int SETTLE   = 4,
    parameter int READ_LAT = 2
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            dl_active,
    input  logic [7:0]      dl_index,
    input  logic            dl_wr,
    input  logic [24:0]     dl_addr,
    input  logic [7:0]      dl_data,
    output logic            dl_wait,
    input  logic            hs_req,
    input  logic            hs_we,
    input  logic [NVAW-1:0] hs_addr,
    input  logic [7:0]      hs_wdata,
    output logic            hs_ack,
    output logic [7:0]      hs_rdata,
    output logic            pause_req,
    input  logic            cpu_paused,
    output logic [AW-1:0]   bus_addr,
    output logic [7:0]      bus_data,
    output logic            bus_wr,
    output logic            bus_nvram_sel,
    input  logic [7:0]      bus_rdata,
    output logic            busy
);

    // One counter serves both the settle wait and the read latency wait.
    localparam int MAXC = (SETTLE > READ_LAT) ? SETTLE : READ_LAT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DL,
        ST_PAUSE,
        ST_SETTLE,
        ST_HS_ACC,
        ST_HS_RD,
        ST_HS_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              req_we_reg, req_we_next;
    logic [NVAW-1:0]   req_addr_reg, req_addr_next;
    logic [7:0]        req_wdata_reg, req_wdata_next;
    logic [AW-1:0]     bus_addr_reg, bus_addr_next;
    logic [7:0]        bus_data_reg, bus_data_next;
    logic              bus_wr_reg, bus_wr_next;
    logic              bus_sel_reg, bus_sel_next;
    logic [7:0]        rdata_reg, rdata_next;

    logic              dl_take;
    logic              hs_phase;
    logic              launch;
    logic              launch_we;
    logic [NVAW-1:0]   launch_addr;
    logic [7:0]        launch_wdata;
    logic              unused_dl_addr;

    // Upper download address bits beyond the bus width are dropped.
    assign unused_dl_addr = &{1'b0, dl_addr};

    // Download bytes are accepted only while the download owns (or is about
    // to own) the bus, and only for the ROM (0) and NVRAM (4) indices.
    assign dl_take = dl_active && dl_wr &&
                     (state_reg == ST_IDLE || state_reg == ST_DL || state_reg == ST_PAUSE) &&
                     (dl_index == 8'd0 || dl_index == 8'd4);

    // Committed to a hiscore access: the download must stall until it ends.
    assign hs_phase = (state_reg == ST_SETTLE) || (state_reg == ST_HS_ACC) ||
                      (state_reg == ST_HS_RD)  || (state_reg == ST_HS_DONE);

    assign dl_wait       = dl_active && hs_phase;
    assign pause_req     = hs_phase || (state_reg == ST_PAUSE);
    assign hs_ack        = (state_reg == ST_HS_DONE);
    assign busy          = (state_reg != ST_IDLE);
    assign hs_rdata      = rdata_reg;
    assign bus_addr      = bus_addr_reg;
    assign bus_data      = bus_data_reg;
    assign bus_wr        = bus_wr_reg;
    assign bus_nvram_sel = bus_sel_reg;

    // Next-state, request latching and registered bus drive decisions.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        req_we_next    = req_we_reg;
        req_addr_next  = req_addr_reg;
        req_wdata_next = req_wdata_reg;
        bus_addr_next  = bus_addr_reg;
        bus_data_next  = bus_data_reg;
        bus_wr_next    = 1'b0;
        bus_sel_next   = bus_sel_reg;
        rdata_next     = rdata_reg;
        launch         = 1'b0;
        launch_we      = req_we_reg;
        launch_addr    = req_addr_reg;
        launch_wdata   = req_wdata_reg;

        if (dl_take) begin
            bus_addr_next = dl_addr[AW-1:0];
            bus_data_next = dl_data;
            bus_wr_next   = 1'b1;
            bus_sel_next  = (dl_index == 8'd4);
        end

        case (state_reg)
            ST_IDLE: begin
                if (dl_active) begin
                    state_next = ST_DL;
                end else if (hs_req) begin
                    state_next     = ST_PAUSE;
                    req_we_next    = hs_we;
                    req_addr_next  = hs_addr;
                    req_wdata_next = hs_wdata;
                end
            end
            ST_DL: begin
                if (!dl_active) state_next = ST_IDLE;
            end
            ST_PAUSE: begin
                // The pending hiscore request survives a download pre-emption;
                // it is simply re-latched from IDLE later.
                if (dl_active) begin
                    state_next = ST_DL;
                end else if (cpu_paused) begin
                    state_next = ST_SETTLE;
                    cnt_next   = CW'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (!cpu_paused) begin
                    state_next = ST_PAUSE;
                end else if (cnt_reg == '0) begin
                    state_next = ST_HS_ACC;
                    launch     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_HS_ACC: begin
                if (req_we_reg) begin
                    state_next = ST_HS_DONE;
                end else begin
                    state_next = ST_HS_RD;
                    cnt_next   = CW'(READ_LAT - 1);
                end
            end
            ST_HS_RD: begin
                if (cnt_reg == '0) begin
                    rdata_next = bus_rdata;
                    state_next = ST_HS_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_HS_DONE: begin
                if (dl_active) begin
                    state_next = ST_DL;
                end else if (hs_req && cpu_paused) begin
                    // Burst: CPU is still paused, go straight to the next access.
                    state_next     = ST_HS_ACC;
                    req_we_next    = hs_we;
                    req_addr_next  = hs_addr;
                    req_wdata_next = hs_wdata;
                    launch         = 1'b1;
                    launch_we      = hs_we;
                    launch_addr    = hs_addr;
                    launch_wdata   = hs_wdata;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Drive the hiscore address (and write data) for the HS_ACC cycle.
        if (launch) begin
            bus_addr_next = AW'(launch_addr);
            bus_sel_next  = 1'b1;
            if (launch_we) begin
                bus_data_next = launch_wdata;
                bus_wr_next   = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            bus_addr_reg  <= '0;
            bus_data_reg  <= '0;
            bus_wr_reg    <= 1'b0;
            bus_sel_reg   <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_we_reg    <= req_we_next;
            req_addr_reg  <= req_addr_next;
            req_wdata_reg <= req_wdata_next;
            bus_addr_reg  <= bus_addr_next;
            bus_data_reg  <= bus_data_next;
            bus_wr_reg    <= bus_wr_next;
            bus_sel_reg   <= bus_sel_next;
            rdata_reg     <= rdata_next;
        end
    end

endmodule
